// File: rtl/mux_sched_pkg.sv
// Shared types and the round-robin pick helper for the 4-channel mux scheduler.
package mux_sched_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CH_SEL_W = 2;

  typedef logic [CH_SEL_W-1:0] ch_idx_t;

  // Result of a round-robin search: winning index plus "any requester valid".
  typedef struct packed {
    logic    any;
    ch_idx_t idx;
  } pick_t;

  // Output stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  // First set bit of valid, searching ptr, ptr+1, ... with natural mod-4 wrap.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] valid, input ch_idx_t ptr);
    pick_t   r;
    ch_idx_t c;
    r = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      c = ptr + ch_idx_t'(k);
      if (!r.any && valid[c]) begin
        r.any = 1'b1;
        r.idx = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_sched_mux.sv
// Pure combinational 4:1 data steering mux built from a ternary chain.
module mux_ternary
  import mux_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  ch_idx_t          i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = (i_sel == ch_idx_t'(0)) ? i_d0 :
               (i_sel == ch_idx_t'(1)) ? i_d1 :
               (i_sel == ch_idx_t'(2)) ? i_d2 :
                                         i_d3;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four valid/ready producers,
// with a single-entry registered output stage and configurable burst length.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned BURST    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  input  logic [WIDTH-1:0]    in2,
  input  logic [WIDTH-1:0]    in3,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
  output logic [WIDTH-1:0]    out,
  output logic [SEL_BITS-1:0] out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  ostate_t          r_state;
  logic [WIDTH-1:0] r_out;
  ch_idx_t          r_sel;
  ch_idx_t          r_ptr;
  logic [CNT_W-1:0] r_cnt;

  pick_t            w_pick;
  logic             w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_mux;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_burst_done;

  // Winner search starts at the current priority pointer.
  assign w_pick = rr_pick(in_valid, r_ptr);

  // Output stage can take a beat when empty or when its beat leaves this cycle.
  assign w_load   = (r_state == ST_EMPTY) || out_ready;
  assign w_accept = w_load && w_pick.any && !rst;

  // Consecutive-grant count: extends only if the pointer holder wins again.
  assign w_cnt_next   = (w_pick.idx == r_ptr) ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
  assign w_burst_done = (w_cnt_next == CNT_W'(BURST));

  mux_ternary #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_d0  (in0),
    .i_d1  (in1),
    .i_d2  (in2),
    .i_d3  (in3),
    .i_sel (w_pick.idx),
    .o_y   (w_mux)
  );

  // One-hot ready to the winning requester; suppressed during reset.
  always_comb begin
    in_ready = '0;
    if (w_accept) begin
      in_ready[w_pick.idx] = 1'b1;
    end
  end

  // Output stage state, data register and burst/priority bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      if (w_pick.any) begin
        r_state <= ST_FULL;
        r_out   <= w_mux;
        r_sel   <= w_pick.idx;
        if (w_burst_done) begin
          r_ptr <= w_pick.idx + ch_idx_t'(1);
          r_cnt <= '0;
        end else begin
          r_ptr <= w_pick.idx;
          r_cnt <= w_cnt_next;
        end
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out       = r_out;
  assign out_sel   = SEL_BITS'(r_sel);
  assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench: two schedulers (BURST=1 and BURST=2) share stimulus;
// a per-instance model pushes expected beats to a scoreboard on acceptance.
module tb_mux_rr_sched;

  logic       clk;
  logic       rst;
  logic [7:0] din [4];
  logic [3:0] in_valid;
  logic       out_ready;

  logic [3:0] rdy_a [2];
  logic [7:0] out_a [2];
  logic [1:0] sel_a [2];
  logic       vld_a [2];

  int n_tests = 0;
  int n_fail  = 0;

  int         burst_of [2] = '{1, 2};
  int         m_ptr    [2];
  int         m_cnt    [2];
  bit         m_full   [2];
  bit         m_new    [2];
  logic [9:0] m_hold   [2];
  int         m_wait   [2][4];
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  int e1a [5] = '{0, 1, 2, 3, 0};
  int e1b [5] = '{0, 0, 1, 1, 2};
  int e2a [6] = '{0, 2, 0, 2, 0, 2};
  int e2b [6] = '{0, 0, 2, 2, 0, 0};
  int e3a [4] = '{0, 2, 0, 2};
  int e3b [4] = '{0, 2, 2, 0};

  mux_rr_sched #(.WIDTH(8), .SEL_BITS(2), .BURST(1)) u_dut_b1 (
    .clk       (clk),
    .rst       (rst),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .in_valid  (in_valid),
    .in_ready  (rdy_a[0]),
    .out       (out_a[0]),
    .out_sel   (sel_a[0]),
    .out_valid (vld_a[0]),
    .out_ready (out_ready)
  );

  mux_rr_sched #(.WIDTH(8), .SEL_BITS(2), .BURST(2)) u_dut_b2 (
    .clk       (clk),
    .rst       (rst),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .in_valid  (in_valid),
    .in_ready  (rdy_a[1]),
    .out       (out_a[1]),
    .out_sel   (sel_a[1]),
    .out_valid (vld_a[1]),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever loses its way.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i]  = 0;
      m_cnt[i]  = 0;
      m_full[i] = 1'b0;
      m_new[i]  = 1'b0;
      m_hold[i] = '0;
      for (int c = 0; c < 4; c++) m_wait[i][c] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Called at a negedge: drive inputs, check ready, advance model, then check outputs.
  task automatic cycle(input logic [3:0] v, input logic rdy);
    logic       ld;
    logic       any;
    int         w;
    int         n;
    logic [3:0] exp_rdy;
    logic [9:0] exp;
    in_valid  = v;
    out_ready = rdy;
    #1;
    for (int i = 0; i < 2; i++) begin
      ld  = !m_full[i] || rdy;
      any = 1'b0;
      w   = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[i] + k) % 4;
        if (!any && v[c]) begin
          any = 1'b1;
          w   = c;
        end
      end
      exp_rdy = (ld && any) ? (4'b0001 << w) : 4'b0000;
      check($sformatf("b%0d in_ready", burst_of[i]), 32'(rdy_a[i]), 32'(exp_rdy));
      check($sformatf("b%0d ready_onehot0", burst_of[i]), 32'($onehot0(rdy_a[i])), 32'd1);
      for (int c = 0; c < 4; c++) if (!v[c]) m_wait[i][c] = 0;
      m_new[i] = 1'b0;
      if (ld && any) begin
        for (int c = 0; c < 4; c++) begin
          if (c == w) begin
            check($sformatf("b%0d starve ch%0d", burst_of[i], c),
                  32'(m_wait[i][c] <= 3 * burst_of[i]), 32'd1);
            m_wait[i][c] = 0;
          end else if (v[c]) begin
            m_wait[i][c]++;
          end
        end
        if (i == 0) q0.push_back({2'(w), din[w]});
        else        q1.push_back({2'(w), din[w]});
        n = (w == m_ptr[i]) ? m_cnt[i] + 1 : 1;
        if (n == burst_of[i]) begin
          m_ptr[i] = (w + 1) % 4;
          m_cnt[i] = 0;
        end else begin
          m_ptr[i] = w;
          m_cnt[i] = n;
        end
        m_full[i] = 1'b1;
        m_new[i]  = 1'b1;
      end else if (ld) begin
        m_full[i] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("b%0d out_valid", burst_of[i]), 32'(vld_a[i]), 32'(m_full[i]));
      if (m_new[i]) begin
        exp = 'x;
        if (i == 0 && q0.size() > 0) exp = q0.pop_front();
        if (i == 1 && q1.size() > 0) exp = q1.pop_front();
        m_hold[i] = exp;
      end
      check($sformatf("b%0d out", burst_of[i]), 32'(out_a[i]), 32'(m_hold[i][7:0]));
      check($sformatf("b%0d out_sel", burst_of[i]), 32'(sel_a[i]), 32'(m_hold[i][9:8]));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_din(input logic [7:0] base);
    for (int c = 0; c < 4; c++) din[c] = base + 8'(c);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    set_din(8'h00);
    model_reset();
    #2;
    in_valid = 4'b1111;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset out_valid", 32'(vld_a[i]), 32'd0);
      check("reset out", 32'(out_a[i]), 32'd0);
      check("reset out_sel", 32'(sel_a[i]), 32'd0);
      check("reset in_ready", 32'(rdy_a[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Full round-robin with every requester valid.
    set_din(8'h10);
    for (int j = 0; j < 5; j++) begin
      cycle(4'b1111, 1'b1);
      check("t1 b1 sel", 32'(sel_a[0]), 32'(e1a[j]));
      check("t1 b2 sel", 32'(sel_a[1]), 32'(e1b[j]));
      check("t1 b1 out", 32'(out_a[0]), 32'(8'h10 + 8'(e1a[j])));
    end

    // Two requesters, bursts of two on the BURST=2 instance.
    pulse_reset();
    for (int j = 0; j < 6; j++) begin
      cycle(4'b0101, 1'b1);
      check("t2 b1 sel", 32'(sel_a[0]), 32'(e2a[j]));
      check("t2 b2 sel", 32'(sel_a[1]), 32'(e2b[j]));
    end

    // Requester 0 drops mid-burst; requester 2 takes over with a fresh count.
    pulse_reset();
    for (int j = 0; j < 4; j++) begin
      cycle((j == 1) ? 4'b0100 : 4'b0101, 1'b1);
      check("t3 b1 sel", 32'(sel_a[0]), 32'(e3a[j]));
      check("t3 b2 sel", 32'(sel_a[1]), 32'(e3b[j]));
    end

    // Backpressure holds the stage, then a simultaneous drain and load.
    pulse_reset();
    for (int c = 0; c < 4; c++) din[c] = 8'hAA;
    cycle(4'b1111, 1'b1);
    set_din(8'h55);
    for (int j = 0; j < 3; j++) begin
      cycle(4'b1111, 1'b0);
      check("t4 hold out", 32'(out_a[0]), 32'h0AA);
      check("t4 hold ready", 32'(rdy_a[0] | rdy_a[1]), 32'd0);
    end
    cycle(4'b1111, 1'b1);
    check("t4 b1 reload", 32'(out_a[0]), 32'h056);
    check("t4 b2 reload", 32'(out_a[1]), 32'h055);
    check("t4 valid kept", 32'(vld_a[0] & vld_a[1]), 32'd1);

    // Sparse: lone grant to channel 3, an idle cycle, then wrap to channel 0.
    pulse_reset();
    set_din(8'h20);
    cycle(4'b1000, 1'b1);
    check("t5 sel3", 32'(sel_a[0]), 32'd3);
    check("t5 out23", 32'(out_a[0]), 32'h023);
    cycle(4'b0000, 1'b1);
    check("t5 idle valid", 32'(vld_a[0] | vld_a[1]), 32'd0);
    cycle(4'b0011, 1'b1);
    check("t5 wrap b1", 32'(sel_a[0]), 32'd0);
    check("t5 wrap b2", 32'(sel_a[1]), 32'd0);

    // Asynchronous reset between clock edges while the stage is full.
    set_din(8'h40);
    cycle(4'b1111, 1'b1);
    in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t6 async valid", 32'(vld_a[i]), 32'd0);
      check("t6 async out", 32'(out_a[i]), 32'd0);
      check("t6 async ready", 32'(rdy_a[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_din(8'h30);
    cycle(4'b1010, 1'b1);
    check("t6 b1 first", 32'(sel_a[0]), 32'd1);
    check("t6 b2 first", 32'(sel_a[1]), 32'd1);
    check("t6 out31", 32'(out_a[0]), 32'h031);

    // Random traffic and backpressure against the scoreboard.
    for (int j = 0; j < 10000; j++) begin
      for (int c = 0; c < 4; c++) din[c] = 8'($urandom_range(0, 255));
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
